spu_decode_stage: RTL and testbench

Register-read and operand-preparation stage of the SPU pipeline, directly upstream of the ID/EX pipeline register. It reads up to three 128-bit source operands from a 128×128-bit register file, builds the 128-bit immediate and computes PC+8. It tracks in-flight destination registers in a scoreboard and stalls the front end until each pending source has been written back. Its outputs feed the ID/EX register inputs combinationally; the register file and scoreboard are sequential.

---
 rtl/spu_pkg.sv | 28 ++
 rtl/spu_decode_stage_if.sv | 42 ++++
 rtl/spu_regfile.sv | 45 ++++
 rtl/spu_decode_stage.sv | 118 +++++++++++
 tb/tb_spu_decode_stage.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spu_pkg.sv
// spu_pkg: shared definitions for the SPU decode stage.
// Register-file geometry, immediate selector encoding and the bit
// positions of the register fields inside a 32-bit instruction word.
package spu_pkg;

  localparam int REG_W    = 128;
  localparam int NUM_REGS = 128;
  localparam int REG_AW   = 7;

  typedef enum logic [1:0] {
    IMM_I7  = 2'd0,
    IMM_I10 = 2'd1,
    IMM_I16 = 2'd2,
    IMM_I18 = 2'd3
  } imm_sel_t;

  // LSB positions of the 7-bit register fields
  localparam int RA_LSB     = 7;
  localparam int RB_LSB     = 14;
  localparam int RC_LSB     = 0;
  localparam int RT_RRR_LSB = 21;
  localparam int RT_LSB     = 0;

  function automatic logic [REG_AW-1:0] reg_field(input logic [31:0] word, input int lsb);
    return word[lsb +: REG_AW];
  endfunction

endpackage

// File: rtl/spu_decode_stage_if.sv
// spu_decode_if: instruction, writeback and operand bundle between the
// IF/ID front end (master) and the decode stage (slave).
interface spu_decode_if #(parameter int PC_bitsize = 32);
  import spu_pkg::*;

  logic                  instr_valid;
  logic [31:0]           instr;
  logic [PC_bitsize-1:0] PC_in;
  logic                  rrr_fmt;
  logic                  uses_ra;
  logic                  uses_rb;
  logic                  uses_rc;
  logic                  writes_rt;
  imm_sel_t              imm_sel;
  logic                  flush;
  logic                  wb_en;
  logic [REG_AW-1:0]     wb_addr;
  logic [REG_W-1:0]      wb_data;

  logic [REG_W-1:0]      ReadData1;
  logic [REG_W-1:0]      ReadData2;
  logic [REG_W-1:0]      ReadData3;
  logic [REG_W-1:0]      immediate;
  logic [PC_bitsize-1:0] PC_plusEight;
  logic                  issue_valid;
  logic                  stall;

  modport master (
    output instr_valid, instr, PC_in, rrr_fmt, uses_ra, uses_rb, uses_rc,
           writes_rt, imm_sel, flush, wb_en, wb_addr, wb_data,
    input  ReadData1, ReadData2, ReadData3, immediate, PC_plusEight,
           issue_valid, stall
  );

  modport slave (
    input  instr_valid, instr, PC_in, rrr_fmt, uses_ra, uses_rb, uses_rc,
           writes_rt, imm_sel, flush, wb_en, wb_addr, wb_data,
    output ReadData1, ReadData2, ReadData3, immediate, PC_plusEight,
           issue_valid, stall
  );

endinterface

// File: rtl/spu_regfile.sv
// spu_regfile: 128 x 128-bit register file, three combinational read
// ports and one write port. A read of the register being written this
// cycle returns the incoming write data.
module spu_regfile
  import spu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] ra_addr,
  input  logic [REG_AW-1:0] rb_addr,
  input  logic [REG_AW-1:0] rc_addr,
  output logic [REG_W-1:0]  ra_data,
  output logic [REG_W-1:0]  rb_data,
  output logic [REG_W-1:0]  rc_data,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [REG_W-1:0]  wdata
);

  logic [REG_W-1:0] mem_q [NUM_REGS];
  logic [REG_W-1:0] mem_d [NUM_REGS];

  // Next register contents: unchanged except the written entry
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) mem_d[i] = mem_q[i];
    if (we) mem_d[waddr] = wdata;
  end

  // Register storage, cleared entry by entry on reset
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= mem_d[i];
    end
  end

  // Read ports with write-through bypass
  always_comb begin
    ra_data = (we && (waddr == ra_addr)) ? wdata : mem_q[ra_addr];
    rb_data = (we && (waddr == rb_addr)) ? wdata : mem_q[rb_addr];
    rc_data = (we && (waddr == rc_addr)) ? wdata : mem_q[rc_addr];
  end

endmodule

// File: rtl/spu_decode_stage.sv
// spu_decode_stage: register read, immediate expansion, PC+8 and
// scoreboard-based hazard stall for the SPU pipeline.
// Optional feature macro: SPU_DECODE_PERF_EN adds a saturating
// stall_cycles counter output.
module spu_decode_stage
  import spu_pkg::*;
#(
  parameter int PC_bitsize = 32
) (
  input  logic        clk,
  input  logic        reset,
  spu_decode_if.slave dec
`ifdef SPU_DECODE_PERF_EN
  ,
  output logic [31:0] stall_cycles
`endif
);

  logic [REG_AW-1:0]   ra_addr;
  logic [REG_AW-1:0]   rb_addr;
  logic [REG_AW-1:0]   rc_addr;
  logic [REG_AW-1:0]   rt_addr;
  logic [REG_W-1:0]    rc_data;
  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_d;
  logic                hazard;
  logic [31:0]         imm_word;
  logic                unused_instr_bits;

  assign unused_instr_bits = ^dec.instr[31:28];

  // Decode register fields; rt moves to the upper field in RRR format
  always_comb begin
    ra_addr = reg_field(dec.instr, RA_LSB);
    rb_addr = reg_field(dec.instr, RB_LSB);
    rc_addr = reg_field(dec.instr, RC_LSB);
    rt_addr = dec.rrr_fmt ? reg_field(dec.instr, RT_RRR_LSB) : reg_field(dec.instr, RT_LSB);
  end

  spu_regfile u_regfile (
    .clk     (clk),
    .reset   (reset),
    .ra_addr (ra_addr),
    .rb_addr (rb_addr),
    .rc_addr (rc_addr),
    .ra_data (dec.ReadData1),
    .rb_data (dec.ReadData2),
    .rc_data (rc_data),
    .we      (dec.wb_en),
    .waddr   (dec.wb_addr),
    .wdata   (dec.wb_data)
  );

  // Only RRR instructions carry an rc operand
  always_comb begin
    dec.ReadData3 = dec.rrr_fmt ? rc_data : '0;
  end

  // Hazard detection: a writeback arriving this cycle releases its reader
  always_comb begin
    hazard = 1'b0;
    if (dec.uses_ra && pending_q[ra_addr] && !(dec.wb_en && dec.wb_addr == ra_addr))
      hazard = 1'b1;
    if (dec.uses_rb && pending_q[rb_addr] && !(dec.wb_en && dec.wb_addr == rb_addr))
      hazard = 1'b1;
    if (dec.rrr_fmt && dec.uses_rc && pending_q[rc_addr] && !(dec.wb_en && dec.wb_addr == rc_addr))
      hazard = 1'b1;
    if (dec.writes_rt && pending_q[rt_addr])
      hazard = 1'b1;
    dec.stall       = !reset && dec.instr_valid && !dec.flush && hazard;
    dec.issue_valid = !reset && dec.instr_valid && !dec.flush && !hazard;
  end

  // Scoreboard next state: clear on writeback, then set on issue so set wins
  always_comb begin
    pending_d = pending_q;
    if (dec.wb_en) pending_d[dec.wb_addr] = 1'b0;
    if (dec.issue_valid && dec.writes_rt) pending_d[rt_addr] = 1'b1;
  end

  // Scoreboard register
  always_ff @(posedge clk) begin
    if (reset) pending_q <= '0;
    else       pending_q <= pending_d;
  end

  // Immediate expansion: 32-bit word replicated into all four slots
  always_comb begin
    case (dec.imm_sel)
      IMM_I7:  imm_word = {{25{dec.instr[20]}}, dec.instr[20:14]};
      IMM_I10: imm_word = {{22{dec.instr[23]}}, dec.instr[23:14]};
      IMM_I16: imm_word = {{16{dec.instr[22]}}, dec.instr[22:7]};
      default: imm_word = {14'd0, dec.instr[24:7]};
    endcase
    dec.immediate    = {4{imm_word}};
    dec.PC_plusEight = dec.PC_in + PC_bitsize'(8);
  end

`ifdef SPU_DECODE_PERF_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] stall_cycles_d;

  // Saturating count of stalled cycles
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (dec.stall && stall_cycles_q != 32'hFFFF_FFFF) stall_cycles_d = stall_cycles_q + 32'd1;
  end

  // Stall counter register
  always_ff @(posedge clk) begin
    if (reset) stall_cycles_q <= '0;
    else       stall_cycles_q <= stall_cycles_d;
  end

  assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_spu_decode_stage.sv
// tb_spu_decode_stage: directed and randomized checks of the SPU decode
// stage against a behavioural model of register file and scoreboard.
// Honours SPU_DECODE_PERF_EN for the stall counter port.
`timescale 1ns/1ps
module tb_spu_decode_stage;
  import spu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  spu_decode_if #(.PC_bitsize(32)) dif ();

`ifdef SPU_DECODE_PERF_EN
  logic [31:0] stall_cycles;
  spu_decode_stage #(.PC_bitsize(32)) dut (.clk(clk), .reset(reset), .dec(dif), .stall_cycles(stall_cycles));
`else
  spu_decode_stage #(.PC_bitsize(32)) dut (.clk(clk), .reset(reset), .dec(dif));
`endif

  int tests_run = 0;
  int tests_failed = 0;

  logic [127:0] ref_regs [128];
  bit           ref_pend [128];
  longint       ref_stall_cnt = 0;

  function automatic logic [6:0] exp_rt();
    return dif.rrr_fmt ? dif.instr[27:21] : dif.instr[6:0];
  endfunction

  function automatic logic [127:0] exp_read(input logic [6:0] a);
    if (dif.wb_en && dif.wb_addr == a) return dif.wb_data;
    return ref_regs[a];
  endfunction

  function automatic bit src_blocked(input bit en, input logic [6:0] a);
    return en && ref_pend[a] && !(dif.wb_en && dif.wb_addr == a);
  endfunction

  function automatic bit exp_stall();
    if (reset || !dif.instr_valid || dif.flush) return 1'b0;
    return src_blocked(dif.uses_ra, dif.instr[13:7]) ||
           src_blocked(dif.uses_rb, dif.instr[20:14]) ||
           src_blocked(dif.uses_rc && dif.rrr_fmt, dif.instr[6:0]) ||
           (dif.writes_rt && ref_pend[exp_rt()]);
  endfunction

  function automatic bit exp_issue();
    return !reset && dif.instr_valid && !dif.flush && !exp_stall();
  endfunction

  function automatic logic [127:0] exp_imm();
    int v;
    logic [31:0] w;
    case (dif.imm_sel)
      IMM_I7:  begin v = int'(dif.instr[20:14]); if (v >= 64)  v = v - 128;   end
      IMM_I10: begin v = int'(dif.instr[23:14]); if (v >= 512) v = v - 1024;  end
      IMM_I16: begin v = int'(dif.instr[22:7]);  if (v >= 32768) v = v - 65536; end
      default: v = int'(dif.instr[24:7]);
    endcase
    w = 32'(v);
    return {w, w, w, w};
  endfunction

  task automatic tick();
    bit st;
    bit iss;
    logic [6:0] rt;
    st = exp_stall();
    iss = exp_issue();
    rt = exp_rt();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 128; i++) begin ref_regs[i] = '0; ref_pend[i] = 1'b0; end
      ref_stall_cnt = 0;
    end else begin
      if (dif.wb_en) begin ref_regs[dif.wb_addr] = dif.wb_data; ref_pend[dif.wb_addr] = 1'b0; end
      if (iss && dif.writes_rt) ref_pend[rt] = 1'b1;
      if (st && ref_stall_cnt < 64'hFFFF_FFFF) ref_stall_cnt++;
    end
    @(negedge clk);
  endtask

  task automatic set_idle();
    dif.instr_valid = 1'b0; dif.instr = '0; dif.PC_in = '0; dif.rrr_fmt = 1'b0;
    dif.uses_ra = 1'b0; dif.uses_rb = 1'b0; dif.uses_rc = 1'b0; dif.writes_rt = 1'b0;
    dif.imm_sel = IMM_I7; dif.flush = 1'b0; dif.wb_en = 1'b0; dif.wb_addr = '0; dif.wb_data = '0;
  endtask

  task automatic set_instr(input logic rrr, input logic [6:0] ra, input logic [6:0] rb,
                           input logic [6:0] low7, input logic [6:0] rt_hi);
    logic [31:0] w;
    w = $urandom;
    w[13:7] = ra; w[20:14] = rb; w[6:0] = low7;
    if (rrr) w[27:21] = rt_hi;
    dif.instr = w;
    dif.rrr_fmt = rrr;
  endtask

  task automatic test_reset();
    set_idle();
    reset = 1'b1;
    dif.instr_valid = 1'b1; dif.uses_ra = 1'b1; dif.writes_rt = 1'b1;
    #1;
    tests_run++; if (dif.stall !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_stall: got %b expected 0", dif.stall); end
    tests_run++; if (dif.issue_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_issue: got %b expected 0", dif.issue_valid); end
    tick(); tick();
    reset = 1'b0;
    set_idle();
    set_instr(1'b1, 7'd5, 7'd6, 7'd7, 7'd9);
    dif.instr_valid = 1'b1; dif.uses_ra = 1'b1; dif.uses_rb = 1'b1; dif.uses_rc = 1'b1;
    #1;
    tests_run++; if (dif.ReadData1 !== '0) begin tests_failed++; $display("[TB] FAIL reset_rd1: got %h expected 0", dif.ReadData1); end
    tests_run++; if (dif.ReadData2 !== '0) begin tests_failed++; $display("[TB] FAIL reset_rd2: got %h expected 0", dif.ReadData2); end
    tests_run++; if (dif.ReadData3 !== '0) begin tests_failed++; $display("[TB] FAIL reset_rd3: got %h expected 0", dif.ReadData3); end
    tests_run++; if (dif.issue_valid !== 1'b1 || dif.stall !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_first_issue: got issue=%b stall=%b expected issue=1 stall=0", dif.issue_valid, dif.stall); end
`ifdef SPU_DECODE_PERF_EN
    tests_run++; if (stall_cycles !== 32'd0) begin tests_failed++; $display("[TB] FAIL reset_perf: got %0d expected 0", stall_cycles); end
`endif
    tick();
  endtask

  task automatic test_bypass();
    logic [127:0] a5;
    a5 = {16{8'hA5}};
    set_idle();
    set_instr(1'b0, 7'd10, 7'd0, 7'd0, 7'd0);
    dif.instr_valid = 1'b1; dif.uses_ra = 1'b1;
    dif.wb_en = 1'b1; dif.wb_addr = 7'd10; dif.wb_data = a5;
    #1;
    tests_run++; if (dif.ReadData1 !== a5) begin tests_failed++; $display("[TB] FAIL bypass_same_cycle: got %h expected %h", dif.ReadData1, a5); end
    tick();
    dif.wb_en = 1'b0;
    #1;
    tests_run++; if (dif.ReadData1 !== a5) begin tests_failed++; $display("[TB] FAIL bypass_next_cycle: got %h expected %h", dif.ReadData1, a5); end
    tick();
  endtask

  task automatic test_stall_release();
    logic [127:0] d;
    d = {$urandom, $urandom, $urandom, $urandom};
    set_idle();
    set_instr(1'b0, 7'd1, 7'd2, 7'd20, 7'd0);
    dif.instr_valid = 1'b1; dif.writes_rt = 1'b1;
    #1;
    tests_run++; if (dif.issue_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL producer_issue: got %b expected 1", dif.issue_valid); end
    tick();
    set_instr(1'b0, 7'd20, 7'd3, 7'd4, 7'd0);
    dif.writes_rt = 1'b0; dif.uses_ra = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      tests_run++; if (dif.stall !== 1'b1 || dif.issue_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL raw_stall_c%0d: got stall=%b issue=%b expected stall=1 issue=0", c, dif.stall, dif.issue_valid); end
      tick();
    end
    dif.wb_en = 1'b1; dif.wb_addr = 7'd20; dif.wb_data = d;
    #1;
    tests_run++; if (dif.stall !== 1'b0 || dif.issue_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL raw_release: got stall=%b issue=%b expected stall=0 issue=1", dif.stall, dif.issue_valid); end
    tests_run++; if (dif.ReadData1 !== d) begin tests_failed++; $display("[TB] FAIL raw_release_data: got %h expected %h", dif.ReadData1, d); end
    tick();
    set_idle();
  endtask

  task automatic test_immediate();
    set_idle();
    set_instr(1'b0, 7'd0, 7'd0, 7'd0, 7'd0);
    dif.instr[23:14] = 10'h3FF; dif.imm_sel = IMM_I10;
    #1;
    tests_run++; if (dif.immediate !== {4{32'hFFFF_FFFF}}) begin tests_failed++; $display("[TB] FAIL imm_i10_neg: got %h expected all ones", dif.immediate); end
    dif.instr[24:7] = 18'h3FFFF; dif.imm_sel = IMM_I18;
    #1;
    tests_run++; if (dif.immediate !== {4{32'h0003_FFFF}}) begin tests_failed++; $display("[TB] FAIL imm_i18: got %h expected 4x0003ffff", dif.immediate); end
    dif.instr[20:14] = 7'h40; dif.imm_sel = IMM_I7;
    #1;
    tests_run++; if (dif.immediate !== {4{32'hFFFF_FFC0}}) begin tests_failed++; $display("[TB] FAIL imm_i7_neg: got %h expected 4xffffffc0", dif.immediate); end
    dif.instr[22:7] = 16'h7FFF; dif.imm_sel = IMM_I16;
    #1;
    tests_run++; if (dif.immediate !== {4{32'h0000_7FFF}}) begin tests_failed++; $display("[TB] FAIL imm_i16_pos: got %h expected 4x00007fff", dif.immediate); end
    for (int i = 0; i < 8; i++) begin
      dif.instr = $urandom; dif.imm_sel = imm_sel_t'($urandom_range(0, 3));
      #1;
      tests_run++; if (dif.immediate !== exp_imm()) begin tests_failed++; $display("[TB] FAIL imm_rand%0d: got %h expected %h", i, dif.immediate, exp_imm()); end
    end
    tick();
  endtask

  task automatic test_flush();
    set_idle();
    set_instr(1'b0, 7'd1, 7'd2, 7'd30, 7'd0);
    dif.instr_valid = 1'b1; dif.writes_rt = 1'b1;
    tick();
    set_instr(1'b0, 7'd30, 7'd2, 7'd3, 7'd0);
    dif.writes_rt = 1'b0; dif.uses_ra = 1'b1; dif.flush = 1'b1;
    #1;
    tests_run++; if (dif.issue_valid !== 1'b0 || dif.stall !== 1'b0) begin tests_failed++; $display("[TB] FAIL flush_kill: got issue=%b stall=%b expected 0 0", dif.issue_valid, dif.stall); end
    tick();
    dif.flush = 1'b0;
    #1;
    tests_run++; if (dif.stall !== 1'b1) begin tests_failed++; $display("[TB] FAIL flush_keeps_pending: got stall=%b expected 1", dif.stall); end
    tick();
    dif.instr_valid = 1'b0; dif.wb_en = 1'b1; dif.wb_addr = 7'd30; dif.wb_data = '1;
    tick();
    set_instr(1'b0, 7'd1, 7'd2, 7'd30, 7'd0);
    dif.instr_valid = 1'b1; dif.uses_ra = 1'b0; dif.writes_rt = 1'b1;
    #1;
    tests_run++; if (dif.issue_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL setwins_issue: got %b expected 1", dif.issue_valid); end
    tick();
    dif.wb_en = 1'b0; dif.writes_rt = 1'b1;
    #1;
    tests_run++; if (dif.stall !== 1'b1) begin tests_failed++; $display("[TB] FAIL waw_stall: got %b expected 1", dif.stall); end
    set_instr(1'b0, 7'd30, 7'd2, 7'd3, 7'd0);
    dif.writes_rt = 1'b0; dif.uses_ra = 1'b1;
    #1;
    tests_run++; if (dif.stall !== 1'b1) begin tests_failed++; $display("[TB] FAIL setwins_pending: got stall=%b expected 1", dif.stall); end
    tick();
    set_idle();
    dif.wb_en = 1'b1; dif.wb_addr = 7'd30; dif.wb_data = '0;
    tick();
    set_idle();
  endtask

  task automatic test_pc_wrap();
    logic [31:0] p;
    set_idle();
    dif.PC_in = 32'hFFFF_FFFC;
    #1;
    tests_run++; if (dif.PC_plusEight !== 32'h0000_0004) begin tests_failed++; $display("[TB] FAIL pc_wrap: got %h expected 00000004", dif.PC_plusEight); end
    for (int i = 0; i < 4; i++) begin
      p = $urandom; dif.PC_in = p;
      #1;
      tests_run++; if (dif.PC_plusEight !== 32'(p + 32'd8)) begin tests_failed++; $display("[TB] FAIL pc_rand%0d: got %h expected %h", i, dif.PC_plusEight, 32'(p + 32'd8)); end
    end
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 99) == 0);
      set_instr(1'($urandom), 7'($urandom_range(0, 7)), 7'($urandom_range(0, 7)),
                7'($urandom_range(0, 7)), 7'($urandom_range(0, 7)));
      dif.instr_valid = ($urandom_range(0, 9) < 8);
      dif.uses_ra = 1'($urandom); dif.uses_rb = 1'($urandom); dif.uses_rc = 1'($urandom);
      dif.writes_rt = 1'($urandom);
      dif.imm_sel = imm_sel_t'($urandom_range(0, 3));
      dif.flush = ($urandom_range(0, 9) == 0);
      dif.wb_en = ($urandom_range(0, 9) < 4);
      dif.wb_addr = 7'($urandom_range(0, 7));
      dif.wb_data = {$urandom, $urandom, $urandom, $urandom};
      dif.PC_in = $urandom;
      #1;
      tests_run++; if (dif.stall !== exp_stall()) begin tests_failed++; $display("[TB] FAIL rand_stall[%0d]: got %b expected %b", n, dif.stall, exp_stall()); end
      tests_run++; if (dif.issue_valid !== exp_issue()) begin tests_failed++; $display("[TB] FAIL rand_issue[%0d]: got %b expected %b", n, dif.issue_valid, exp_issue()); end
      tests_run++; if (dif.ReadData1 !== exp_read(dif.instr[13:7])) begin tests_failed++; $display("[TB] FAIL rand_rd1[%0d]: got %h expected %h", n, dif.ReadData1, exp_read(dif.instr[13:7])); end
      tests_run++; if (dif.ReadData2 !== exp_read(dif.instr[20:14])) begin tests_failed++; $display("[TB] FAIL rand_rd2[%0d]: got %h expected %h", n, dif.ReadData2, exp_read(dif.instr[20:14])); end
      if (dif.rrr_fmt) begin
        tests_run++; if (dif.ReadData3 !== exp_read(dif.instr[6:0])) begin tests_failed++; $display("[TB] FAIL rand_rd3[%0d]: got %h expected %h", n, dif.ReadData3, exp_read(dif.instr[6:0])); end
      end
      tests_run++; if (dif.immediate !== exp_imm()) begin tests_failed++; $display("[TB] FAIL rand_imm[%0d]: got %h expected %h", n, dif.immediate, exp_imm()); end
      tests_run++; if (dif.PC_plusEight !== 32'(dif.PC_in + 32'd8)) begin tests_failed++; $display("[TB] FAIL rand_pc8[%0d]: got %h expected %h", n, dif.PC_plusEight, 32'(dif.PC_in + 32'd8)); end
`ifdef SPU_DECODE_PERF_EN
      tests_run++; if (stall_cycles !== 32'(ref_stall_cnt)) begin tests_failed++; $display("[TB] FAIL rand_perf[%0d]: got %0d expected %0d", n, stall_cycles, ref_stall_cnt); end
`endif
      tick();
    end
    reset = 1'b0;
    set_idle();
  endtask

`ifdef SPU_DECODE_PERF_EN
  task automatic test_perf();
    set_idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_instr(1'b0, 7'd1, 7'd2, 7'd50, 7'd0);
    dif.instr_valid = 1'b1; dif.writes_rt = 1'b1;
    tick();
    set_instr(1'b0, 7'd50, 7'd2, 7'd3, 7'd0);
    dif.writes_rt = 1'b0; dif.uses_ra = 1'b1;
    for (int c = 0; c < 5; c++) tick();
    set_idle();
    #1;
    tests_run++; if (stall_cycles !== 32'd5) begin tests_failed++; $display("[TB] FAIL perf_count: got %0d expected 5", stall_cycles); end
    tick();
  endtask
`endif

  initial begin
    reset = 1'b1;
    set_idle();
    @(negedge clk);
    test_reset();
    test_bypass();
    test_stall_release();
    test_immediate();
    test_flush();
    test_pc_wrap();
    test_random();
`ifdef SPU_DECODE_PERF_EN
    test_perf();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
